// File: rtl/issue_scoreboard.sv
`default_nettype none
// issue_scoreboard: per-register RAW/WAW scoreboard, ALU/MUL/MEM writeback reservation and write-port arbiter.
// Optional macro ISSUE_WB_BYPASS_EN: a register written back this cycle counts as ready for RAW/WAW checks.
module issue_scoreboard #(
  parameter int ADDR_W  = 6,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [1:0]        issue_unit,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  output logic              halt,
  input  logic              mem_done,
  output logic              mem_wb_grant,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [1:0]        wb_src
);

  localparam int         NREG      = 1 << ADDR_W;
  localparam logic [1:0] UNIT_ALU  = 2'd0;
  localparam logic [1:0] UNIT_MUL  = 2'd1;
  localparam logic [1:0] UNIT_MEM  = 2'd2;
  localparam logic [1:0] UNIT_NONE = 2'd3;

  logic [NREG-1:0]                pending;
  logic [MUL_LAT:1]               res_valid;
  logic [MUL_LAT:1][1:0]          res_src;
  logic [MUL_LAT:1][ADDR_W-1:0]   res_rd;
  logic                           mem_busy;
  logic [ADDR_W-1:0]              mem_rd;

  logic [NREG-1:0]                hazard_pend;
  logic [MUL_LAT:1]               eff_valid;
  logic [MUL_LAT:1][1:0]          eff_src;
  logic [MUL_LAT:1][ADDR_W-1:0]   eff_rd;
  logic rd_nz, is_alu, is_mul, is_mem, writes, mem_wait, fire;

  assign rd_nz    = (issue_rd != '0);
  assign is_alu   = (issue_unit == UNIT_ALU);
  assign is_mul   = (issue_unit == UNIT_MUL);
  assign is_mem   = (issue_unit == UNIT_MEM);
  assign writes   = rd_nz && (issue_unit != UNIT_NONE);
  assign mem_wait = mem_done & mem_busy;
  assign fire     = issue_valid & issue_ready;
  assign halt     = issue_valid & ~issue_ready;

  assign mem_wb_grant = mem_wait & ~res_valid[1];

  always_comb begin
    hazard_pend = pending;
`ifdef ISSUE_WB_BYPASS_EN
    if (wb_en) hazard_pend[wb_rd] = 1'b0;
`endif
  end

  always_comb begin
    issue_ready = 1'b1;
    if (hazard_pend[issue_rs1] || hazard_pend[issue_rs2]) issue_ready = 1'b0;
    if (writes && hazard_pend[issue_rd])                  issue_ready = 1'b0;
    if (is_alu && rd_nz && res_valid[1])                  issue_ready = 1'b0;
    if (is_mul && rd_nz && res_valid[MUL_LAT])            issue_ready = 1'b0;
    if (is_mem && mem_busy)                               issue_ready = 1'b0;
    // Hold off new ALU/MUL results while MEM waits, so its grant wait stays bounded
    if ((is_alu || is_mul) && rd_nz && mem_wait && !mem_wb_grant) issue_ready = 1'b0;
    if (is_alu && rd_nz && mem_wb_grant)                  issue_ready = 1'b0;
  end

  // res[k] holds the writeback due k cycles from now; a firing ALU/MUL joins its slot this cycle
  always_comb begin
    eff_valid = res_valid;
    eff_src   = res_src;
    eff_rd    = res_rd;
    if (fire && rd_nz && is_alu) begin
      eff_valid[1] = 1'b1;
      eff_src[1]   = UNIT_ALU;
      eff_rd[1]    = issue_rd;
    end
    if (fire && rd_nz && is_mul) begin
      eff_valid[MUL_LAT] = 1'b1;
      eff_src[MUL_LAT]   = UNIT_MUL;
      eff_rd[MUL_LAT]    = issue_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending   <= '0;
      res_valid <= '0;
      res_src   <= '0;
      res_rd    <= '0;
      mem_busy  <= 1'b0;
      mem_rd    <= '0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_src    <= '0;
    end else begin
      for (int k = 1; k < MUL_LAT; k++) begin
        res_valid[k] <= eff_valid[k+1];
        res_src[k]   <= eff_src[k+1];
        res_rd[k]    <= eff_rd[k+1];
      end
      res_valid[MUL_LAT] <= 1'b0;
      res_src[MUL_LAT]   <= '0;
      res_rd[MUL_LAT]    <= '0;

      if (eff_valid[1]) begin
        wb_en  <= 1'b1;
        wb_rd  <= eff_rd[1];
        wb_src <= eff_src[1];
      end else begin
        wb_en  <= mem_wb_grant && (mem_rd != '0);
        wb_rd  <= mem_rd;
        wb_src <= UNIT_MEM;
      end

      // Set after clear: only reachable through the bypassed WAW case, where the new owner wins
      if (wb_en) pending[wb_rd] <= 1'b0;
      if (fire && writes) pending[issue_rd] <= 1'b1;
      pending[0] <= 1'b0;

      if (mem_wb_grant) mem_busy <= 1'b0;
      if (fire && is_mem) begin
        mem_busy <= 1'b1;
        mem_rd   <= issue_rd;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// tb_issue_scoreboard: scenario tasks with a writeback scoreboard queue for issue_scoreboard.
module tb_issue_scoreboard;

  localparam int         ADDR_W  = 6;
  localparam int         MUL_LAT = 3;
  localparam logic [1:0] U_ALU = 2'd0, U_MUL = 2'd1, U_MEM = 2'd2, U_NONE = 2'd3;
`ifdef ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              issue_valid;
  logic [1:0]        issue_unit;
  logic [ADDR_W-1:0] issue_rs1, issue_rs2, issue_rd;
  logic              issue_ready, halt;
  logic              mem_done, mem_wb_grant;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_rd;
  logic [1:0]        wb_src;

  issue_scoreboard #(.ADDR_W(ADDR_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_unit(issue_unit),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .halt(halt),
    .mem_done(mem_done), .mem_wb_grant(mem_wb_grant),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_src(wb_src)
  );

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] rd;
    logic [1:0]        src;
  } wb_t;

  wb_t               expq[$];
  int                cyc;
  int                errors;
  int                checks;
  logic [ADDR_W-1:0] m_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [1:0] u, input logic [ADDR_W-1:0] s1,
                       input logic [ADDR_W-1:0] s2, input logic [ADDR_W-1:0] d);
    issue_valid = v; issue_unit = u; issue_rs1 = s1; issue_rs2 = s2; issue_rd = d;
  endtask

  // Push expected writebacks for this cycle, step one clock, then pop/compare the writeback
  task automatic commit(input bit exp_fire, input bit exp_grant);
    wb_t e;
    int  idx;
    checks++;
    if (mem_wb_grant && issue_valid && issue_ready && issue_unit == U_ALU && issue_rd != '0) begin
      errors++;
      $display("FAIL one_wb_port: cyc %0d ALU fired during MEM grant", cyc);
    end
    if (exp_fire && issue_unit == U_ALU && issue_rd != '0) begin
      e.cyc = cyc + 1; e.rd = issue_rd; e.src = 2'd0; expq.push_back(e);
    end
    if (exp_fire && issue_unit == U_MUL && issue_rd != '0) begin
      e.cyc = cyc + MUL_LAT; e.rd = issue_rd; e.src = 2'd1; expq.push_back(e);
    end
    if (exp_grant && m_rd != '0) begin
      e.cyc = cyc + 1; e.rd = m_rd; e.src = 2'd2; expq.push_back(e);
    end
    if (exp_fire && issue_unit == U_MEM) m_rd = issue_rd;
    @(posedge clk); #1;
    idx = -1;
    foreach (expq[i]) if (expq[i].cyc == cyc) idx = i;
    if (wb_en === 1'b1 || idx >= 0) begin
      checks++;
      if (idx < 0) begin
        errors++;
        $display("FAIL wb_unexpected: cyc %0d got wb_en=%b rd=%0d src=%0d, want no writeback", cyc, wb_en, wb_rd, wb_src);
      end else if (wb_en !== 1'b1 || wb_rd !== expq[idx].rd || wb_src !== expq[idx].src) begin
        errors++;
        $display("FAIL wb_data: cyc %0d got en=%b rd=%0d src=%0d, want en=1 rd=%0d src=%0d",
                 cyc, wb_en, wb_rd, wb_src, expq[idx].rd, expq[idx].src);
      end
      if (idx >= 0) expq.delete(idx);
    end
  endtask

  task automatic idle(input int n);
    drive(1'b0, U_NONE, '0, '0, '0);
    repeat (n) commit(1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b0; mem_done = 1'b1; m_rd = '0;
    drive(1'b1, U_ALU, 6'd5, 6'd6, 6'd7);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wb_en !== 1'b0)       begin errors++; $display("FAIL rst_wb_en: got %b want 0", wb_en); end
    checks++; if (wb_rd !== '0)         begin errors++; $display("FAIL rst_wb_rd: got %0d want 0", wb_rd); end
    checks++; if (wb_src !== 2'd0)      begin errors++; $display("FAIL rst_wb_src: got %0d want 0", wb_src); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", issue_ready); end
    checks++; if (halt !== 1'b0)        begin errors++; $display("FAIL rst_halt: got %b want 0", halt); end
    checks++; if (mem_wb_grant !== 1'b0) begin errors++; $display("FAIL rst_grant: got %b want 0", mem_wb_grant); end
    mem_done = 1'b0;
    drive(1'b0, U_NONE, '0, '0, '0);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_raw;
    drive(1'b1, U_ALU, 6'd0, 6'd0, 6'd5); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_t0_ready: got %b want 1", issue_ready); end
    commit(1'b1, 1'b0);
    drive(1'b1, U_ALU, 6'd5, 6'd0, 6'd10); #1;
    checks++; if (issue_ready !== BYP) begin errors++; $display("FAIL raw_t1_ready: got %b want %b", issue_ready, BYP); end
    checks++; if (halt !== !BYP)       begin errors++; $display("FAIL raw_t1_halt: got %b want %b", halt, !BYP); end
    checks++; if (wb_en !== 1'b1 || wb_rd !== 6'd5 || wb_src !== 2'd0) begin
      errors++; $display("FAIL raw_t1_wb: got en=%b rd=%0d src=%0d want en=1 rd=5 src=0", wb_en, wb_rd, wb_src);
    end
    commit(BYP, 1'b0);
`ifndef ISSUE_WB_BYPASS_EN
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_t2_ready: got %b want 1", issue_ready); end
    commit(1'b1, 1'b0);
`endif
    idle(3);
  endtask

  task automatic test_mul_port;
    drive(1'b1, U_MUL, 6'd0, 6'd0, 6'd7); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL mul_t0_ready: got %b want 1", issue_ready); end
    commit(1'b1, 1'b0);
    idle(1);
    drive(1'b1, U_ALU, 6'd0, 6'd0, 6'd8); #1;
    checks++; if (issue_ready !== 1'b0 || halt !== 1'b1) begin
      errors++; $display("FAIL mul_t2_port: got ready=%b halt=%b want ready=0 halt=1", issue_ready, halt);
    end
    commit(1'b0, 1'b0);
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL mul_t3_ready: got %b want 1", issue_ready); end
    commit(1'b1, 1'b0);
    idle(3);
  endtask

  task automatic test_mem_arb;
    drive(1'b1, U_MEM, 6'd0, 6'd0, 6'd9); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL arb_mem_ready: got %b want 1", issue_ready); end
    commit(1'b1, 1'b0);
    drive(1'b1, U_MUL, 6'd0, 6'd0, 6'd3); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL arb_mul_ready: got %b want 1", issue_ready); end
    commit(1'b1, 1'b0);
    idle(1);
    mem_done = 1'b1;
    drive(1'b1, U_ALU, 6'd0, 6'd0, 6'd11); #1;
    checks++; if (mem_wb_grant !== 1'b0) begin errors++; $display("FAIL arb_t3_grant: got %b want 0", mem_wb_grant); end
    checks++; if (issue_ready !== 1'b0)  begin errors++; $display("FAIL arb_t3_alu: got ready=%b want 0", issue_ready); end
    drive(1'b1, U_MUL, 6'd0, 6'd0, 6'd12); #1;
    checks++; if (issue_ready !== 1'b0)  begin errors++; $display("FAIL arb_t3_mul: got ready=%b want 0", issue_ready); end
    commit(1'b0, 1'b0);
    drive(1'b1, U_ALU, 6'd0, 6'd0, 6'd11); #1;
    checks++; if (mem_wb_grant !== 1'b1) begin errors++; $display("FAIL arb_t4_grant: got %b want 1", mem_wb_grant); end
    checks++; if (issue_ready !== 1'b0 || halt !== 1'b1) begin
      errors++; $display("FAIL arb_t4_alu: got ready=%b halt=%b want ready=0 halt=1", issue_ready, halt);
    end
    commit(1'b0, 1'b1);
    mem_done = 1'b0; #1;
    checks++; if (mem_wb_grant !== 1'b0) begin errors++; $display("FAIL arb_t5_grant: got %b want 0", mem_wb_grant); end
    checks++; if (issue_ready !== 1'b1)  begin errors++; $display("FAIL arb_t5_alu: got ready=%b want 1", issue_ready); end
    commit(1'b1, 1'b0);
    idle(3);
  endtask

  task automatic test_mem_busy;
    drive(1'b1, U_MEM, 6'd0, 6'd0, 6'd20); #1;
    commit(1'b1, 1'b0);
    drive(1'b1, U_MEM, 6'd0, 6'd0, 6'd21); #1;
    checks++; if (issue_ready !== 1'b0 || halt !== 1'b1) begin
      errors++; $display("FAIL busy_t1: got ready=%b halt=%b want ready=0 halt=1", issue_ready, halt);
    end
    commit(1'b0, 1'b0);
    mem_done = 1'b1; #1;
    checks++; if (mem_wb_grant !== 1'b1) begin errors++; $display("FAIL busy_t2_grant: got %b want 1", mem_wb_grant); end
    checks++; if (issue_ready !== 1'b0)  begin errors++; $display("FAIL busy_t2_ready: got %b want 0", issue_ready); end
    commit(1'b0, 1'b1);
    mem_done = 1'b0; #1;
    checks++; if (issue_ready !== 1'b1)  begin errors++; $display("FAIL busy_t3_ready: got %b want 1", issue_ready); end
    commit(1'b1, 1'b0);
    idle(1);
    mem_done = 1'b1; #1;
    checks++; if (mem_wb_grant !== 1'b1) begin errors++; $display("FAIL busy_rd21_grant: got %b want 1", mem_wb_grant); end
    commit(1'b0, 1'b1);
    mem_done = 1'b0;
    drive(1'b1, U_MEM, 6'd0, 6'd0, 6'd0); #1;
    checks++; if (issue_ready !== 1'b1)  begin errors++; $display("FAIL store_ready: got %b want 1", issue_ready); end
    commit(1'b1, 1'b0);
    drive(1'b1, U_MEM, 6'd0, 6'd0, 6'd22);
    mem_done = 1'b1; #1;
    checks++; if (issue_ready !== 1'b0)  begin errors++; $display("FAIL store_busy: got ready=%b want 0", issue_ready); end
    checks++; if (mem_wb_grant !== 1'b1) begin errors++; $display("FAIL store_grant: got %b want 1", mem_wb_grant); end
    commit(1'b0, 1'b1);
    mem_done = 1'b0; #1;
    checks++; if (issue_ready !== 1'b1)  begin errors++; $display("FAIL mem22_ready: got %b want 1", issue_ready); end
    commit(1'b1, 1'b0);
    drive(1'b0, U_NONE, '0, '0, '0);
    mem_done = 1'b1; #1;
    commit(1'b0, 1'b1);
    mem_done = 1'b0;
    idle(1);
    mem_done = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (mem_wb_grant !== 1'b0) begin errors++; $display("FAIL idle_done_grant: got %b want 0", mem_wb_grant); end
      commit(1'b0, 1'b0);
    end
    mem_done = 1'b0;
    idle(2);
  endtask

  task automatic test_back_to_back;
    drive(1'b1, U_ALU, 6'd0, 6'd0, 6'd0); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_rd0_ready: got %b want 1", issue_ready); end
    commit(1'b1, 1'b0);
    drive(1'b1, U_ALU, 6'd0, 6'd0, 6'd0); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_rs0_ready: got %b want 1", issue_ready); end
    commit(1'b1, 1'b0);
    drive(1'b1, U_NONE, 6'd0, 6'd0, 6'd13); #1;
    commit(1'b1, 1'b0);
    drive(1'b1, U_ALU, 6'd13, 6'd0, 6'd14); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_none_rd: got ready=%b want 1", issue_ready); end
    commit(1'b1, 1'b0);
    idle(3);
  endtask

  task automatic test_waw;
    bit exp;
    drive(1'b1, U_MUL, 6'd0, 6'd0, 6'd4); #1;
    commit(1'b1, 1'b0);
    drive(1'b1, U_ALU, 6'd0, 6'd0, 6'd4);
    for (int k = 1; k <= MUL_LAT; k++) begin
      #1;
      exp = (k == MUL_LAT) && BYP;
      checks++; if (issue_ready !== exp) begin errors++; $display("FAIL waw_k%0d: got ready=%b want %b", k, issue_ready, exp); end
      commit(exp, 1'b0);
      if (exp) break;
    end
`ifndef ISSUE_WB_BYPASS_EN
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL waw_after_wb: got ready=%b want 1", issue_ready); end
    commit(1'b1, 1'b0);
`endif
    idle(3);
  endtask

  task automatic test_reset_mid;
    drive(1'b1, U_MUL, 6'd0, 6'd0, 6'd15); #1;
    commit(1'b1, 1'b0);
    drive(1'b1, U_ALU, 6'd0, 6'd0, 6'd14); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rm_alu_ready: got %b want 1", issue_ready); end
    commit(1'b1, 1'b0);
    drive(1'b1, U_MUL, 6'd15, 6'd14, 6'd15);
    reset = 1'b0; #1;
    expq.delete();
    m_rd = '0;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL rm_wb_en: got %b want 0", wb_en); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_in_reset: got %b want 1", issue_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    idle(4);
    drive(1'b1, U_ALU, 6'd15, 6'd14, 6'd15); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rm_after_release: got ready=%b want 1", issue_ready); end
    commit(1'b1, 1'b0);
    idle(3);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_alu_raw;
    test_mul_port;
    test_mem_arb;
    test_mem_busy;
    test_back_to_back;
    test_waw;
    test_reset_mid;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL wb_drain: got %0d outstanding writebacks want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
